irrigation_zone_scheduler: RTL
==============================

Name: irrigation_zone_scheduler

Overview:
- Time-shares one pump among N_ZONES garden zones, each with its own valve.
- Latches per-zone watering requests (short or long) and serves them one zone at a time in round-robin order.
- Runs a seconds-based timer from a cycle prescaler and inserts a pump rest gap between zones.
- Sits between the debounced KEY/sensor request logic and the valve/pump/LED/HEX drivers.

Parameters:
- N_ZONES, 4, number of zones; legal range 2..8.
- CYCLES_PER_SEC, 50000000, CLOCK_50 cycles per second. Benches use 10.
- SHORT_SEC, 3, short watering duration in seconds.
- LONG_SEC, 6, long watering duration in seconds; must be ≤15.
- GAP_SEC, 1, pump rest between consecutive zones in seconds; must be ≥1.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_short  in  N_ZONES  per-zone short-watering request. Active-high, one-cycle pulses, already synchronised.
- req_long  in  N_ZONES  per-zone long-watering request. Active-high pulses.
- abort  in  1  active-high level; cancels everything.
- valve  out  N_ZONES  one-hot open valve; all zero when not watering.
- pump_on  out  1  pump enable.
- busy  out  1  high in WATER or GAP.
- active_zone  out  3  index of the zone being watered; 0 when not in WATER.
- sec_remaining  out  4  seconds left in WATER, counting dur..1; 0 otherwise.
- pending  out  N_ZONES  zones with a latched, unserved request.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, all outputs 0, pending=0, pending_long=0, prescaler=0, round-robin pointer=0.
- Request latch, applied every cycle:
  - req_short[i] or req_long[i] sets pending[i] on that edge.
  - req_long[i] also sets pending_long[i].
  - A short request never clears pending_long.
  - Short and long in the same cycle count as long.
  - A request for the zone currently being watered re-latches it as pending for a later turn.
- States are IDLE, WATER and GAP.
- IDLE:
  - If pending is nonzero, the arbiter grants the first pending zone at or after ptr, searching upward with wrap.
  - On the next edge: state=WATER, valve=onehot(g), pump_on=1, active_zone=g.
  - The same edge loads the duration (LONG_SEC if pending_long[g], else SHORT_SEC), clears pending[g] and pending_long[g], sets ptr=(g+1) mod N_ZONES and zeroes the prescaler.
  - Latency: a request sampled at edge k makes pending visible after edge k; valve and pump assert after edge k+1.
- WATER:
  - The prescaler counts 0..CYCLES_PER_SEC-1. On wrap, sec_remaining decrements.
  - When sec_remaining would become 0, the next state is GAP: valve=0, pump_on=0, prescaler=0.
  - The valve stays open for exactly dur×CYCLES_PER_SEC cycles.
- GAP:
  - Lasts exactly GAP_SEC×CYCLES_PER_SEC cycles with pump and valves off and busy=1, then returns to IDLE.
  - Requests arriving during GAP are still latched.
  - Consecutive zones are therefore separated by GAP_SEC×CPS+1 cycles of closed valves.
- abort=1 has priority over every other event on that edge:
  - state=IDLE, all outputs 0, pending and pending_long cleared, prescaler=0.
  - Requests arriving in the same cycle as abort are dropped.
  - ptr is unchanged.
- valve is always one-hot or zero. pump_on=1 only when valve is nonzero.

Decomposition:
- irrigation_pkg holds:
  - the state enum: IDLE=2'b00, WATER=2'b01, GAP=2'b10; the code 2'b11 forces IDLE.
  - DUR_W=4 and the default duration constants.
- One sub-module, rr_arbiter, with parameter N. Inputs are a request vector and the pointer; outputs are grant_valid and grant_idx. It is purely combinational.
- The prescaler and FSM stay in the top-level module.

Test Plan (CYCLES_PER_SEC=10, N_ZONES=4):
- Reset mid-WATER:
  - Stimulus: zone 2 watering, reset_n pulsed low.
  - Required: valve=0, pump_on=0 and pending=0 immediately, before the next edge. After release, state stays IDLE with no requests.
- Single short request:
  - Stimulus: req_short[1] pulsed at edge k.
  - Required: valve=4'b0010 from edge k+2 for exactly 30 cycles, with sec_remaining going 3,2,1. Then 10 GAP cycles, busy=1 throughout.
- Round-robin order:
  - Stimulus: req_long[0], req_short[2] and req_short[3] in the same cycle.
  - Required: zone 0 is served for 60 cycles, then zone 2 for 30, then zone 3 for 30. Each is preceded by a 10-cycle gap plus one IDLE cycle.
- Upgrade and coincidence:
  - Stimulus: req_short[3], then req_long[3] while pending.
  - Required: zone 3 waters 60 cycles. A separate case with req_short[1] and req_long[1] in the same cycle also waters 60 cycles.
- Re-request:
  - Stimulus: req_short[0] during zone 0's WATER.
  - Required: pending[0]=1, and zone 0 is served again after the GAP when no other zone is pending.
- Abort:
  - Stimulus: abort with zone 1 watering, pending=4'b1100, and req_short[0] in the same cycle.
  - Required: after the edge, all outputs and pending are 0, and ptr=2 is retained.

Source files
------------

// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared types and constants for the irrigation zone scheduler.
// The state code 2'b11 is unused; the FSM treats it as a return to IDLE.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WATER = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int DUR_W              = 4;
    localparam int IDX_W              = 3;
    localparam int DEF_CYCLES_PER_SEC = 50000000;
    localparam int DEF_SHORT_SEC      = 3;
    localparam int DEF_LONG_SEC       = 6;
    localparam int DEF_GAP_SEC        = 1;

endpackage

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting zone
// at or after ptr, searching upward with wrap-around.
module rr_arbiter
    import irrigation_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_idx [N];

    // rot[gi] is the request of the zone gi places after ptr
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            logic [N-1:0]   sel;
            assign sum         = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign rot_idx[gi] = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                                          : sum[IDX_W-1:0];
            assign sel         = {{(N - 1){1'b0}}, 1'b1} << rot_idx[gi];
            assign rot[gi]     = |(req & sel);
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_valid = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Time-shares one pump among N_ZONES valves: latches short/long requests,
// serves them round-robin with a seconds timer and a pump rest gap.
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_ZONES        = 4,
    parameter int CYCLES_PER_SEC = DEF_CYCLES_PER_SEC,
    parameter int SHORT_SEC      = DEF_SHORT_SEC,
    parameter int LONG_SEC       = DEF_LONG_SEC,
    parameter int GAP_SEC        = DEF_GAP_SEC
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [N_ZONES-1:0] req_short,
    input  logic [N_ZONES-1:0] req_long,
    input  logic               abort,
    output logic [N_ZONES-1:0] valve,
    output logic               pump_on,
    output logic               busy,
    output logic [IDX_W-1:0]   active_zone,
    output logic [DUR_W-1:0]   sec_remaining,
    output logic [N_ZONES-1:0] pending
);

    localparam int               PW        = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
    localparam logic [DUR_W-1:0] SHORT_DUR = DUR_W'(SHORT_SEC);
    localparam logic [DUR_W-1:0] LONG_DUR  = DUR_W'(LONG_SEC);
    localparam logic [DUR_W-1:0] GAP_DUR   = DUR_W'(GAP_SEC);

    state_t             state_reg;
    logic [N_ZONES-1:0] valve_reg;
    logic               pump_on_reg;
    logic [IDX_W-1:0]   active_zone_reg;
    logic [DUR_W-1:0]   sec_remaining_reg;
    logic [DUR_W-1:0]   gap_left_reg;
    logic [N_ZONES-1:0] pending_reg;
    logic [N_ZONES-1:0] pending_long_reg;
    logic [PW-1:0]      presc_reg;
    logic [IDX_W-1:0]   ptr_reg;

    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [N_ZONES-1:0] grant_onehot;
    logic               grant_now;
    logic               presc_wrap;
    logic [N_ZONES-1:0] pending_next;
    logic [N_ZONES-1:0] pending_long_next;

    rr_arbiter #(
        .N (N_ZONES)
    ) u_arbiter (
        .req         (pending_reg),
        .ptr         (ptr_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant_onehot = {{(N_ZONES - 1){1'b0}}, 1'b1} << grant_idx;
    assign grant_now    = (state_reg == IDLE) && grant_valid;
    assign presc_wrap   = (presc_reg == PRESC_MAX);

    // New requests are OR-ed in after the grant clears its bit, so a zone
    // asking again while being served keeps a turn for later.
    always_comb begin
        pending_next      = pending_reg;
        pending_long_next = pending_long_reg;
        if (grant_now) begin
            pending_next      = pending_next & ~grant_onehot;
            pending_long_next = pending_long_next & ~grant_onehot;
        end
        pending_next      = pending_next | req_short | req_long;
        pending_long_next = pending_long_next | req_long;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            valve_reg         <= '0;
            pump_on_reg       <= 1'b0;
            active_zone_reg   <= '0;
            sec_remaining_reg <= '0;
            gap_left_reg      <= '0;
            pending_reg       <= '0;
            pending_long_reg  <= '0;
            presc_reg         <= '0;
            ptr_reg           <= '0;
        end else if (abort) begin
            state_reg         <= IDLE;
            valve_reg         <= '0;
            pump_on_reg       <= 1'b0;
            active_zone_reg   <= '0;
            sec_remaining_reg <= '0;
            gap_left_reg      <= '0;
            pending_reg       <= '0;
            pending_long_reg  <= '0;
            presc_reg         <= '0;
        end else begin
            pending_reg      <= pending_next;
            pending_long_reg <= pending_long_next;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_reg         <= WATER;
                        valve_reg         <= grant_onehot;
                        pump_on_reg       <= 1'b1;
                        active_zone_reg   <= grant_idx;
                        sec_remaining_reg <= (|(pending_long_reg & grant_onehot)) ? LONG_DUR : SHORT_DUR;
                        presc_reg         <= '0;
                        ptr_reg           <= (grant_idx == IDX_W'(N_ZONES - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                WATER: begin
                    if (presc_wrap) begin
                        presc_reg <= '0;
                        if (sec_remaining_reg == DUR_W'(1)) begin
                            state_reg         <= GAP;
                            valve_reg         <= '0;
                            pump_on_reg       <= 1'b0;
                            active_zone_reg   <= '0;
                            sec_remaining_reg <= '0;
                            gap_left_reg      <= GAP_DUR;
                        end else begin
                            sec_remaining_reg <= sec_remaining_reg - 1'b1;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (presc_wrap) begin
                        presc_reg <= '0;
                        if (gap_left_reg == DUR_W'(1)) begin
                            state_reg    <= IDLE;
                            gap_left_reg <= '0;
                        end else begin
                            gap_left_reg <= gap_left_reg - 1'b1;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    valve_reg         <= '0;
                    pump_on_reg       <= 1'b0;
                    active_zone_reg   <= '0;
                    sec_remaining_reg <= '0;
                    gap_left_reg      <= '0;
                    presc_reg         <= '0;
                end
            endcase
        end
    end

    assign valve         = valve_reg;
    assign pump_on       = pump_on_reg;
    assign busy          = (state_reg == WATER) || (state_reg == GAP);
    assign active_zone   = active_zone_reg;
    assign sec_remaining = sec_remaining_reg;
    assign pending       = pending_reg;

endmodule
